// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch PC sequencer.
// Holds the fetch PC, applies redirects by priority, and parks redirects that
// arrive during a stall until the stall lifts. Also drives the instruction SRAM
// enable and flags misaligned fetch addresses.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall_f,
  input  logic        flush_exc,
  input  logic [31:0] exc_pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_f,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  output logic        fetch_valid,
  output logic        addr_err_f
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic        pend_valid_r, pend_valid_nxt_s;
  logic [31:0] pend_pc_r, pend_pc_nxt_s;
  logic [31:0] src_target_s;
  logic        addr_err_s;

  // Select the redirect target named by pc_src; PLUS4 wraps at 32 bits.
  always_comb begin
    src_target_s = pc_r + 32'd4;
    case (pc_src)
      2'b00:   src_target_s = pc_r + 32'd4;
      2'b01:   src_target_s = branch_target;
      2'b10:   src_target_s = jump_target;
      2'b11:   src_target_s = jr_target;
      default: src_target_s = pc_r + 32'd4;
    endcase
  end

  // Next-state, next-PC and redirect-buffer logic.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    pend_valid_nxt_s = pend_valid_r;
    pend_pc_nxt_s    = pend_pc_r;
    case (state_r)
      BOOT: begin
        // Redirect inputs are ignored here; the first real fetch is RESET_PC.
        state_nxt_s = RUN;
        pc_nxt_s    = RESET_PC;
      end
      RUN, HOLD: begin
        if (flush_exc) begin
          // Exception redirect wins even over a stall and drops any parked redirect.
          state_nxt_s      = RUN;
          pc_nxt_s         = exc_pc;
          pend_valid_nxt_s = 1'b0;
        end else if (stall_f) begin
          // Hold the address; remember the most recent redirect seen while stalled.
          state_nxt_s = HOLD;
          pc_nxt_s    = pc_r;
          if (pc_src != 2'b00) begin
            pend_valid_nxt_s = 1'b1;
            pend_pc_nxt_s    = src_target_s;
          end else begin
            pend_valid_nxt_s = pend_valid_r;
            pend_pc_nxt_s    = pend_pc_r;
          end
        end else if (pend_valid_r) begin
          // A parked redirect takes precedence over whatever pc_src says now.
          state_nxt_s      = RUN;
          pc_nxt_s         = pend_pc_r;
          pend_valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s      = RUN;
          pc_nxt_s         = src_target_s;
          pend_valid_nxt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s      = BOOT;
        pc_nxt_s         = RESET_PC;
        pend_valid_nxt_s = 1'b0;
        pend_pc_nxt_s    = 32'd0;
      end
    endcase
  end

  // State, PC and redirect-buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= BOOT;
      pc_r         <= RESET_PC;
      pend_valid_r <= 1'b0;
      pend_pc_r    <= 32'd0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      pend_pc_r    <= pend_pc_nxt_s;
    end
  end

  // Fetch-side outputs decoded from registered state and PC.
  always_comb begin
    addr_err_s = (pc_r[1:0] != 2'b00);
    if (state_r == BOOT) begin
      inst_sram_en = 1'b0;
      fetch_valid  = 1'b0;
    end else begin
      inst_sram_en = ~addr_err_s;
      fetch_valid  = 1'b1;
    end
  end

  assign pc_f           = pc_r;
  assign inst_sram_addr = pc_r;
  assign addr_err_f     = addr_err_s;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed-vector bench for fetch_ctrl with hand-computed expectations.
module tb_fetch_ctrl;

  logic        clk;
  logic        resetn;
  logic        stall_f;
  logic        flush_exc;
  logic [31:0] exc_pc;
  logic [1:0]  pc_src;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] pc_f;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic        fetch_valid;
  logic        addr_err_f;

  int n_vec;
  int n_err;

  fetch_ctrl #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .stall_f        (stall_f),
    .flush_exc      (flush_exc),
    .exc_pc         (exc_pc),
    .pc_src         (pc_src),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .jr_target      (jr_target),
    .pc_f           (pc_f),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_addr (inst_sram_addr),
    .fetch_valid    (fetch_valid),
    .addr_err_f     (addr_err_f)
  );

  // 10 ns free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %08h, expected %08h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check PC plus the three status outputs in one go.
  task automatic check_fetch(input string tag, input logic [31:0] pc, input logic en,
                             input logic fv, input logic err);
    check_val({tag, ".pc"},   pc_f, pc);
    check_val({tag, ".addr"}, inst_sram_addr, pc);
    check_val({tag, ".en"},   {31'd0, inst_sram_en}, {31'd0, en});
    check_val({tag, ".fv"},   {31'd0, fetch_valid}, {31'd0, fv});
    check_val({tag, ".err"},  {31'd0, addr_err_f}, {31'd0, err});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    resetn = 1'b0; stall_f = 1'b0; flush_exc = 1'b0; exc_pc = 32'd0;
    pc_src = 2'b00; branch_target = 32'd0; jump_target = 32'd0; jr_target = 32'd0;

    // Reset with noisy redirect inputs present.
    @(negedge clk);
    flush_exc = 1'b1; exc_pc = 32'h1234_5678; pc_src = 2'b01; branch_target = 32'h0000_1000;
    tick(); tick();
    check_fetch("reset", 32'hBFC0_0000, 1'b0, 1'b0, 1'b0);

    // Release reset: BOOT cycle, then sequential fetch.
    flush_exc = 1'b0; pc_src = 2'b00;
    resetn = 1'b1;
    check_fetch("boot", 32'hBFC0_0000, 1'b0, 1'b0, 1'b0);
    tick(); check_fetch("run0", 32'hBFC0_0000, 1'b1, 1'b1, 1'b0);
    tick(); check_fetch("run1", 32'hBFC0_0004, 1'b1, 1'b1, 1'b0);
    tick(); check_fetch("run2", 32'hBFC0_0008, 1'b1, 1'b1, 1'b0);
    tick(); check_fetch("run3", 32'hBFC0_000C, 1'b1, 1'b1, 1'b0);
    tick(); check_fetch("run4", 32'hBFC0_0010, 1'b1, 1'b1, 1'b0);

    // Branch redirect, one-cycle latency.
    pc_src = 2'b01; branch_target = 32'hBFC0_0100;
    tick(); check_fetch("br", 32'hBFC0_0100, 1'b1, 1'b1, 1'b0);
    pc_src = 2'b00;
    tick(); check_fetch("br+4", 32'hBFC0_0104, 1'b1, 1'b1, 1'b0);

    // Three stalled cycles with a JR redirect parked in the second.
    stall_f = 1'b1;
    tick(); check_fetch("st1", 32'hBFC0_0104, 1'b1, 1'b1, 1'b0);
    pc_src = 2'b11; jr_target = 32'h8000_1000;
    tick(); check_fetch("st2", 32'hBFC0_0104, 1'b1, 1'b1, 1'b0);
    pc_src = 2'b00;
    tick(); check_fetch("st3", 32'hBFC0_0104, 1'b1, 1'b1, 1'b0);
    stall_f = 1'b0; pc_src = 2'b10; jump_target = 32'h0000_4000;
    tick(); check_fetch("jr_pend", 32'h8000_1000, 1'b1, 1'b1, 1'b0);
    pc_src = 2'b00;

    // Flush during a stall overrides and discards a parked branch.
    stall_f = 1'b1; pc_src = 2'b01; branch_target = 32'h1234_5670;
    tick(); check_fetch("st_pend", 32'h8000_1000, 1'b1, 1'b1, 1'b0);
    pc_src = 2'b00; flush_exc = 1'b1; exc_pc = 32'hBFC0_0380;
    tick(); check_fetch("flush", 32'hBFC0_0380, 1'b1, 1'b1, 1'b0);
    flush_exc = 1'b0;
    tick(); check_fetch("flush_st", 32'hBFC0_0380, 1'b1, 1'b1, 1'b0);
    stall_f = 1'b0;
    tick(); check_fetch("flush_rel", 32'hBFC0_0384, 1'b1, 1'b1, 1'b0);

    // Misaligned jump: no SRAM access, PC keeps advancing.
    pc_src = 2'b10; jump_target = 32'h8000_0002;
    tick(); check_fetch("mis", 32'h8000_0002, 1'b0, 1'b1, 1'b1);
    pc_src = 2'b00;
    tick(); check_fetch("mis+4", 32'h8000_0006, 1'b0, 1'b1, 1'b1);

    // Top-of-address-space wrap.
    pc_src = 2'b10; jump_target = 32'hFFFF_FFFC;
    tick(); check_fetch("top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    pc_src = 2'b00;
    tick(); check_fetch("wrap", 32'h0000_0000, 1'b1, 1'b1, 1'b0);

    // Reset during HOLD with a parked redirect.
    stall_f = 1'b1; pc_src = 2'b10; jump_target = 32'h5555_5550;
    tick(); check_fetch("hold_pend", 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    resetn = 1'b0; pc_src = 2'b00;
    tick(); check_fetch("rst_hold", 32'hBFC0_0000, 1'b0, 1'b0, 1'b0);

    // BOOT ignores redirect requests, including flush.
    resetn = 1'b1; stall_f = 1'b0;
    flush_exc = 1'b1; exc_pc = 32'hDEAD_BEE0; pc_src = 2'b01; branch_target = 32'h0BAD_0000;
    tick(); check_fetch("boot_ign", 32'hBFC0_0000, 1'b1, 1'b1, 1'b0);
    flush_exc = 1'b0; pc_src = 2'b00;
    tick(); check_fetch("no_pend", 32'hBFC0_0004, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
